wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 42 ++++
 rtl/wb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Result-source and register-file write bus of the write-back arbiter.
//
// Handshake: on each rising clk edge, source i transfers one {addr, data}
// result exactly when src_valid[i] && src_ready[i]. A source holding valid
// keeps addr/data stable until that edge. src_ready[i] never depends on
// src_valid[i] or on a same-cycle dequeue.
interface wb_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int NUM_SRC    = 4
);
   logic [NUM_SRC-1:0]                 src_valid;
   logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] src_addr;
   logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data;
   logic [NUM_SRC-1:0]                 src_ready;

   logic                  write_En;
   logic [ADDR_WIDTH-1:0] write_Addr;
   logic [DATA_WIDTH-1:0] write_Data;
   logic                  write_En_2;
   logic [ADDR_WIDTH-1:0] write_Addr_2;
   logic [DATA_WIDTH-1:0] write_Data_2;
   logic                  pending;

   // Arbiter side
   modport slave (
      input  src_valid, src_addr, src_data,
      output src_ready,
      output write_En, write_Addr, write_Data,
      output write_En_2, write_Addr_2, write_Data_2,
      output pending
   );

   // Functional units / register file side
   modport master (
      output src_valid, src_addr, src_data,
      input  src_ready,
      input  write_En, write_Addr, write_Data,
      input  write_En_2, write_Addr_2, write_Data_2,
      input  pending
   );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-source result FIFOs drained round-robin onto two
// register-file write ports, never writing the same register on both ports
// in one cycle. Results to register 0 are accepted and dropped.
module wb_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int NUM_SRC    = 4,
   parameter int FIFO_DEPTH = 2
) (
   input logic        clk,
   input logic        rst,
   input logic        flush,
   wb_arbiter_if.slave bus
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(NUM_SRC);
   localparam int EW = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
   localparam logic [SW:0]   NSRC     = (SW + 1)'(NUM_SRC);
   localparam logic [SW-1:0] LAST_SRC = SW'(NUM_SRC - 1);

   // FIFO storage and bookkeeping
   logic [EW-1:0] mem_q    [NUM_SRC][FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q [NUM_SRC];
   logic [PW-1:0] rd_ptr_q [NUM_SRC];
   logic [CW-1:0] occ_q    [NUM_SRC];

   // Per-source combinational view
   logic [NUM_SRC-1:0]    ready_c;
   logic [NUM_SRC-1:0]    push;
   logic [NUM_SRC-1:0]    pop;
   logic [NUM_SRC-1:0]    non_empty;
   logic [ADDR_WIDTH-1:0] head_addr [NUM_SRC];
   logic [DATA_WIDTH-1:0] head_data [NUM_SRC];

   // Arbitration
   logic [SW-1:0] rr_ptr_q, rr_ptr_d;
   logic          g1_vld, g2_vld;
   logic [SW-1:0] g1_idx, g2_idx, last_idx;
   logic [SW:0]   scan_sum;
   logic [SW-1:0] scan_idx;

   // Write port registers
   logic                  write_en_q, write_en2_q;
   logic [ADDR_WIDTH-1:0] write_addr_q, write_addr2_q;
   logic [DATA_WIDTH-1:0] write_data_q, write_data2_q;

   // Per-source ready, enqueue qualification and FIFO head extraction
   always_comb begin
      ready_c   = '0;
      push      = '0;
      non_empty = '0;
      head_addr = '{default: '0};
      head_data = '{default: '0};
      for (int i = 0; i < NUM_SRC; i++) begin
         ready_c[i]   = (occ_q[i] != FULL) && !flush;
         // Register 0 is hardwired: handshake completes but nothing is stored
         push[i]      = bus.src_valid[i] && ready_c[i] && (bus.src_addr[i] != '0);
         non_empty[i] = (occ_q[i] != '0);
         head_addr[i] = mem_q[i][rd_ptr_q[i]][EW-1:DATA_WIDTH];
         head_data[i] = mem_q[i][rd_ptr_q[i]][DATA_WIDTH-1:0];
      end
   end

   // Round-robin scan from rr_ptr picking up to two non-conflicting heads
   always_comb begin
      g1_vld   = 1'b0;
      g1_idx   = '0;
      g2_vld   = 1'b0;
      g2_idx   = '0;
      scan_sum = '0;
      scan_idx = '0;
      pop      = '0;
      last_idx = '0;
      rr_ptr_d = rr_ptr_q;
      for (int k = 0; k < NUM_SRC; k++) begin
         scan_sum = {1'b0, rr_ptr_q} + (SW + 1)'(k);
         if (scan_sum >= NSRC) scan_sum = scan_sum - NSRC;
         scan_idx = scan_sum[SW-1:0];
         if (non_empty[scan_idx]) begin
            if (!g1_vld) begin
               g1_vld = 1'b1;
               g1_idx = scan_idx;
            end else if (!g2_vld && (head_addr[scan_idx] != head_addr[g1_idx])) begin
               // Same-register results stay queued so the two ports never collide
               g2_vld = 1'b1;
               g2_idx = scan_idx;
            end
         end
      end
      if (g1_vld) pop[g1_idx] = 1'b1;
      if (g2_vld) pop[g2_idx] = 1'b1;
      last_idx = g2_vld ? g2_idx : g1_idx;
      if (g1_vld) rr_ptr_d = (last_idx == LAST_SRC) ? '0 : last_idx + 1'b1;
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            occ_q[i]    <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            occ_q[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
            if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
            case ({push[i], pop[i]})
               2'b10:   occ_q[i] <= occ_q[i] + 1'b1;
               2'b01:   occ_q[i] <= occ_q[i] - 1'b1;
               default: occ_q[i] <= occ_q[i];
            endcase
         end
      end
   end

   // FIFO entry storage; contents are don't-care while occupancy is zero
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= {bus.src_addr[i], bus.src_data[i]};
      end
   end

   // Registered write ports and round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q      <= '0;
         write_en_q    <= 1'b0;
         write_addr_q  <= '0;
         write_data_q  <= '0;
         write_en2_q   <= 1'b0;
         write_addr2_q <= '0;
         write_data2_q <= '0;
      end else if (flush) begin
         rr_ptr_q    <= '0;
         write_en_q  <= 1'b0;
         write_en2_q <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         write_en_q  <= g1_vld;
         write_en2_q <= g2_vld;
         if (g1_vld) begin
            write_addr_q <= head_addr[g1_idx];
            write_data_q <= head_data[g1_idx];
         end
         if (g2_vld) begin
            write_addr2_q <= head_addr[g2_idx];
            write_data2_q <= head_data[g2_idx];
         end
      end
   end

   assign bus.src_ready    = ready_c;
   assign bus.write_En     = write_en_q;
   assign bus.write_Addr   = write_addr_q;
   assign bus.write_Data   = write_data_q;
   assign bus.write_En_2   = write_en2_q;
   assign bus.write_Addr_2 = write_addr2_q;
   assign bus.write_Data_2 = write_data2_q;
   assign bus.pending      = (|non_empty) | write_en_q | write_en2_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: latency, dual issue, same-register
// conflict, register-0 discard, back-pressure with ordering and fairness,
// flush and asynchronous reset.
module tb_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 6;
   localparam int NS = 4;
   localparam int FD = 2;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic flush = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SRC(NS)) bus ();

   wb_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SRC(NS), .FIFO_DEPTH(FD)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .flush(flush),
      .bus  (bus)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.src_valid = '0;
      bus.src_addr  = '0;
      bus.src_data  = '0;
   endtask

   task automatic send(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.src_valid[s] = 1'b1;
      bus.src_addr[s]  = a;
      bus.src_data[s]  = d;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      #1 rst = 1'b1;
      #2;
      n_cmp++; if (bus.write_En !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b exp 0", bus.write_En); end
      n_cmp++; if (bus.write_En_2 !== 1'b0) begin n_err++; $display("FAIL rst_en2: got %b exp 0", bus.write_En_2); end
      n_cmp++; if (bus.write_Addr !== '0) begin n_err++; $display("FAIL rst_addr: got %0d exp 0", bus.write_Addr); end
      n_cmp++; if (bus.write_Data_2 !== '0) begin n_err++; $display("FAIL rst_data2: got %h exp 0", bus.write_Data_2); end
      n_cmp++; if (bus.src_ready !== 4'hF) begin n_err++; $display("FAIL rst_ready: got %b exp 1111", bus.src_ready); end
      n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL rst_pending: got %b exp 0", bus.pending); end
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      send(0, 6'd5, 32'hDEAD_BEEF);
      tick();
      idle_inputs();
      n_cmp++; if (bus.write_En !== 1'b0) begin n_err++; $display("FAIL single_t1_en: got %b exp 0", bus.write_En); end
      n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL single_t1_pending: got %b exp 1", bus.pending); end
      tick();
      n_cmp++; if (bus.write_En !== 1'b1) begin n_err++; $display("FAIL single_en: got %b exp 1", bus.write_En); end
      n_cmp++; if (bus.write_Addr !== 6'd5) begin n_err++; $display("FAIL single_addr: got %0d exp 5", bus.write_Addr); end
      n_cmp++; if (bus.write_Data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_data: got %h exp deadbeef", bus.write_Data); end
      n_cmp++; if (bus.write_En_2 !== 1'b0) begin n_err++; $display("FAIL single_en2: got %b exp 0", bus.write_En_2); end
      tick();
      n_cmp++; if (bus.write_En !== 1'b0) begin n_err++; $display("FAIL single_after_en: got %b exp 0", bus.write_En); end
      n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL single_after_pending: got %b exp 0", bus.pending); end
   endtask

   task automatic test_dual_issue();
      do_flush();
      send(1, 6'd7, 32'h0000_0111);
      send(2, 6'd9, 32'h0000_0222);
      tick();
      idle_inputs();
      tick();
      n_cmp++; if (bus.write_En !== 1'b1 || bus.write_Addr !== 6'd7 || bus.write_Data !== 32'h111) begin
         n_err++; $display("FAIL dual_p1: got en=%b addr=%0d data=%h exp en=1 addr=7 data=111", bus.write_En, bus.write_Addr, bus.write_Data);
      end
      n_cmp++; if (bus.write_En_2 !== 1'b1 || bus.write_Addr_2 !== 6'd9 || bus.write_Data_2 !== 32'h222) begin
         n_err++; $display("FAIL dual_p2: got en=%b addr=%0d data=%h exp en=1 addr=9 data=222", bus.write_En_2, bus.write_Addr_2, bus.write_Data_2);
      end
      // rr_ptr is now 3, so source 3 must win port 1 over source 0
      send(0, 6'd4, 32'h0000_0444);
      send(3, 6'd6, 32'h0000_0666);
      tick();
      idle_inputs();
      tick();
      n_cmp++; if (bus.write_En !== 1'b1 || bus.write_Addr !== 6'd6 || bus.write_Data !== 32'h666) begin
         n_err++; $display("FAIL rr_p1: got en=%b addr=%0d data=%h exp en=1 addr=6 data=666", bus.write_En, bus.write_Addr, bus.write_Data);
      end
      n_cmp++; if (bus.write_En_2 !== 1'b1 || bus.write_Addr_2 !== 6'd4) begin
         n_err++; $display("FAIL rr_p2: got en=%b addr=%0d exp en=1 addr=4", bus.write_En_2, bus.write_Addr_2);
      end
      tick();
   endtask

   task automatic test_conflict();
      do_flush();
      send(0, 6'd12, 32'h0000_AAAA);
      send(1, 6'd12, 32'h0000_BBBB);
      tick();
      idle_inputs();
      tick();
      n_cmp++; if (bus.write_En !== 1'b1 || bus.write_Addr !== 6'd12 || bus.write_Data !== 32'hAAAA) begin
         n_err++; $display("FAIL conflict_first: got en=%b addr=%0d data=%h exp en=1 addr=12 data=aaaa", bus.write_En, bus.write_Addr, bus.write_Data);
      end
      n_cmp++; if (bus.write_En_2 !== 1'b0) begin n_err++; $display("FAIL conflict_first_en2: got %b exp 0", bus.write_En_2); end
      tick();
      n_cmp++; if (bus.write_En !== 1'b1 || bus.write_Addr !== 6'd12 || bus.write_Data !== 32'hBBBB) begin
         n_err++; $display("FAIL conflict_second: got en=%b addr=%0d data=%h exp en=1 addr=12 data=bbbb", bus.write_En, bus.write_Addr, bus.write_Data);
      end
      n_cmp++; if (bus.write_En_2 !== 1'b0) begin n_err++; $display("FAIL conflict_second_en2: got %b exp 0", bus.write_En_2); end
      tick();
      n_cmp++; if (bus.write_En !== 1'b0) begin n_err++; $display("FAIL conflict_done_en: got %b exp 0", bus.write_En); end
   endtask

   task automatic test_addr_zero();
      logic seen;
      do_flush();
      send(0, 6'd0, 32'h0000_1234);
      #1;
      n_cmp++; if (bus.src_ready[0] !== 1'b1) begin n_err++; $display("FAIL zero_ready: got %b exp 1", bus.src_ready[0]); end
      tick();
      idle_inputs();
      n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL zero_pending: got %b exp 0", bus.pending); end
      seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
         seen = seen | bus.write_En | bus.write_En_2;
         tick();
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL zero_write: got %b exp 0", seen); end
   endtask

   task automatic test_back_to_back();
      int                  sent [NS];
      int                  wr   [NS];
      int                  waitc[NS];
      int                  max_wait;
      int                  total;
      logic [NS-1:0]       acc;
      logic [NS-1:0]       got;
      logic [NS-1:0]       exp_rdy [5];
      logic                en_p;
      logic [AW-1:0]       a_p;
      logic [DW-1:0]       d_p;
      logic [DW-1:0]       d_exp;
      int                  s_p;
      int                  item_p;
      exp_rdy = '{4'hF, 4'hF, 4'h3, 4'hC, 4'h3};
      for (int s = 0; s < NS; s++) begin sent[s] = 0; wr[s] = 0; waitc[s] = 0; end
      max_wait = 0;
      do_flush();
      for (int c = 0; c < 10; c++) begin
         for (int s = 0; s < NS; s++) begin
            if (sent[s] < 3) send(s, AW'(8 * s + sent[s] + 1), {16'hC0DE, 8'(s), 8'(sent[s])});
            else bus.src_valid[s] = 1'b0;
         end
         #1;
         if (c < 5) begin
            n_cmp++; if (bus.src_ready !== exp_rdy[c]) begin
               n_err++; $display("FAIL b2b_ready cycle %0d: got %b exp %b", c, bus.src_ready, exp_rdy[c]);
            end
         end
         acc = bus.src_valid & bus.src_ready;
         tick();
         for (int s = 0; s < NS; s++) if (acc[s]) sent[s]++;
         got = '0;
         if (bus.write_En && bus.write_En_2) begin
            n_cmp++; if (bus.write_Addr === bus.write_Addr_2) begin
               n_err++; $display("FAIL b2b_same_addr: both ports addr %0d, required distinct", bus.write_Addr);
            end
         end
         for (int p = 0; p < 2; p++) begin
            en_p = (p == 0) ? bus.write_En   : bus.write_En_2;
            a_p  = (p == 0) ? bus.write_Addr : bus.write_Addr_2;
            d_p  = (p == 0) ? bus.write_Data : bus.write_Data_2;
            if (en_p) begin
               s_p    = (int'(a_p) - 1) / 8;
               item_p = (int'(a_p) - 1) % 8;
               n_cmp++;
               if (a_p == '0 || s_p >= NS) begin
                  n_err++; $display("FAIL b2b_addr port %0d: got addr %0d, required one of the sent addresses", p, a_p);
               end else begin
                  d_exp = {16'hC0DE, 8'(s_p), 8'(wr[s_p])};
                  if (item_p != wr[s_p] || d_p !== d_exp) begin
                     n_err++; $display("FAIL b2b_order src %0d: got item %0d data %h exp item %0d data %h", s_p, item_p, d_p, wr[s_p], d_exp);
                  end
                  wr[s_p]++;
                  got[s_p] = 1'b1;
               end
            end
         end
         for (int s = 0; s < NS; s++) begin
            if (got[s]) waitc[s] = 0;
            else if (sent[s] > wr[s]) waitc[s]++;
            if (waitc[s] > max_wait) max_wait = waitc[s];
         end
      end
      idle_inputs();
      total = 0;
      for (int s = 0; s < NS; s++) total += wr[s];
      n_cmp++; if (total != 12) begin n_err++; $display("FAIL b2b_total: got %0d writes exp 12", total); end
      n_cmp++; if (max_wait > 2) begin n_err++; $display("FAIL b2b_starve: got wait %0d exp <= 2", max_wait); end
      n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL b2b_pending: got %b exp 0", bus.pending); end
   endtask

   task automatic test_flush_rst();
      logic seen;
      do_flush();
      for (int s = 0; s < NS; s++) send(s, AW'(40 + s), 32'h0000_F000 + s);
      tick();
      flush = 1'b1;
      #1;
      n_cmp++; if (bus.src_ready !== 4'h0) begin n_err++; $display("FAIL flush_ready: got %b exp 0000", bus.src_ready); end
      tick();
      flush = 1'b0;
      idle_inputs();
      n_cmp++; if (bus.write_En !== 1'b0 || bus.write_En_2 !== 1'b0) begin
         n_err++; $display("FAIL flush_en: got %b/%b exp 0/0", bus.write_En, bus.write_En_2);
      end
      n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL flush_pending: got %b exp 0", bus.pending); end
      seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         seen = seen | bus.write_En | bus.write_En_2 | bus.pending;
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_residue: got %b exp 0", seen); end

      for (int s = 0; s < NS; s++) send(s, AW'(50 + s), 32'h0000_E000 + s);
      tick();
      idle_inputs();
      tick();
      n_cmp++; if (bus.write_En !== 1'b1 || bus.write_Addr !== 6'd50) begin
         n_err++; $display("FAIL pre_rst_write: got en=%b addr=%0d exp en=1 addr=50", bus.write_En, bus.write_Addr);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (bus.write_En !== 1'b0 || bus.write_En_2 !== 1'b0) begin
         n_err++; $display("FAIL midrst_en: got %b/%b exp 0/0", bus.write_En, bus.write_En_2);
      end
      n_cmp++; if (bus.write_Addr !== '0 || bus.write_Data !== '0) begin
         n_err++; $display("FAIL midrst_port1: got addr=%0d data=%h exp 0/0", bus.write_Addr, bus.write_Data);
      end
      n_cmp++; if (bus.src_ready !== 4'hF) begin n_err++; $display("FAIL midrst_ready: got %b exp 1111", bus.src_ready); end
      n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL midrst_pending: got %b exp 0", bus.pending); end
      tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         seen = seen | bus.write_En | bus.write_En_2 | bus.pending;
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL postrst_residue: got %b exp 0", seen); end
      send(2, 6'd33, 32'h0000_5555);
      tick();
      idle_inputs();
      tick();
      n_cmp++; if (bus.write_En !== 1'b1 || bus.write_Addr !== 6'd33 || bus.write_Data !== 32'h5555) begin
         n_err++; $display("FAIL postrst_write: got en=%b addr=%0d data=%h exp en=1 addr=33 data=5555", bus.write_En, bus.write_Addr, bus.write_Data);
      end
      tick();
   endtask

   // Test sequence and report
   initial begin
      test_reset();
      test_single();
      test_dual_issue();
      test_conflict();
      test_addr_zero();
      test_back_to_back();
      test_flush_rst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
